// File: rtl/traffic_light_phase_controller.sv
// ---------------------------------------------------------------------------
// traffic_light_phase_controller
//
// Two-direction (north-south / east-west) signal controller that cycles
//   AR_NS -> NS_G -> NS_Y -> AR_EW -> EW_G -> EW_Y -> AR_NS
// with a per-state down-counting timer. Each state lasts its length in
// en=1 cycles; en=0 freezes state and timer.
//
// Optional feature, enabled by defining the macro PED_REQUEST_EN:
//   pedestrian request input (ped_req) and walk lamp output (walk). A request
//   is latched and serviced by stretching the next all-red phase to
//   WALK_CYCLES with walk=1. With the macro undefined the ports, the pending
//   flag and the walk logic do not exist.
//
// Lamps and walk are registered Moore outputs. phase is the raw state code.
// ---------------------------------------------------------------------------
module traffic_light_phase_controller #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int WALK_CYCLES   = 6,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic [2:0] phase
`ifdef PED_REQUEST_EN
  ,
  input  logic       ped_req,
  output logic       walk
`endif
);

  // Codes 6 and 7 are unused and recover to AR_NS.
  typedef enum logic [2:0] {
    AR_NS = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_EW = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5
  } state_t;

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}
  typedef logic [5:0] lamps_t;

  localparam lamps_t LAMPS_ALL_RED = 6'b100_100;

  // Timer load values are (length - 1) so that timer==0 marks the last cycle.
  localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
`ifdef PED_REQUEST_EN
  localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_CYCLES - 1);
`endif

  // Successor in the fixed phase ring; unused codes fall back to AR_NS.
  function automatic state_t succ_of(input state_t s);
    case (s)
      AR_NS:   succ_of = NS_G;
      NS_G:    succ_of = NS_Y;
      NS_Y:    succ_of = AR_EW;
      AR_EW:   succ_of = EW_G;
      EW_G:    succ_of = EW_Y;
      default: succ_of = AR_NS;
    endcase
  endfunction

  // Timer value loaded on entry to a state (non-walk length).
  function automatic logic [CNT_W-1:0] load_of(input state_t s);
    case (s)
      NS_G, EW_G: load_of = GREEN_LOAD;
      NS_Y, EW_Y: load_of = YELLOW_LOAD;
      default:    load_of = ALLRED_LOAD;
    endcase
  endfunction

  // Moore lamp decode; only one direction can ever be non-red.
  function automatic lamps_t lamps_of(input state_t s);
    case (s)
      NS_G:    lamps_of = 6'b001_100;
      NS_Y:    lamps_of = 6'b010_100;
      EW_G:    lamps_of = 6'b100_001;
      EW_Y:    lamps_of = 6'b100_010;
      default: lamps_of = LAMPS_ALL_RED;
    endcase
  endfunction

  function automatic logic is_all_red(input state_t s);
    is_all_red = (s == AR_NS) || (s == AR_EW);
  endfunction

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic             enter;
  lamps_t           lamps;

`ifdef PED_REQUEST_EN
  logic pending;
  logic pending_next;
  logic walk_next;
  logic req_now;
  logic walk_entry;
`endif

  // Next-state and timer computation, including walk-phase stretching.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    timer_next = timer;
    enter      = 1'b0;

    if (state > EW_Y) begin
      // Unused code: recover regardless of en.
      state_next = AR_NS;
      enter      = 1'b1;
    end else if (en) begin
      if (timer == '0) begin
        state_next = succ_of(state);
        enter      = 1'b1;
      end else begin
        timer_next = timer - CNT_W'(1);
      end
    end

    if (enter) begin
      timer_next = load_of(state_next);
    end

`ifdef PED_REQUEST_EN
    // A request arriving on the entry edge itself is serviced by this entry.
    req_now      = pending | ped_req;
    walk_entry   = enter && is_all_red(state_next) && req_now;
    pending_next = walk_entry ? 1'b0 : req_now;
    walk_next    = enter ? walk_entry : walk;
    if (walk_entry) begin
      timer_next = WALK_LOAD;
    end
`endif
  end

  // State, timer and registered outputs; reset discards any remaining time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: all state, including the registered outputs, is reset asynchronously so the lamps go red without a clock.
      state <= AR_NS;
      timer <= ALLRED_LOAD;
      lamps <= LAMPS_ALL_RED;
`ifdef PED_REQUEST_EN
      pending <= 1'b0;
      walk    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state <= state_next;
      timer <= timer_next;
      lamps <= lamps_of(state_next);
`ifdef PED_REQUEST_EN
      pending <= pending_next;
      walk    <= walk_next;
`endif
    end
  end

  assign {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = lamps;
  assign phase = state;

endmodule

// File: tb/tb_traffic_light_phase_controller.sv
// ---------------------------------------------------------------------------
// Testbench for traffic_light_phase_controller (GREEN=5, YELLOW=2, ALLRED=1,
// WALK=4). A behavioural elapsed-count model pushes expected outputs into a
// scoreboard queue when stimulus is driven; each is popped and compared one
// time unit after the clock edge. A vector table covers the phase ring and
// the en freeze; hand-written sequences cover async reset and walk phases.
// ---------------------------------------------------------------------------
module tb_traffic_light_phase_controller;

  localparam int G  = 5;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int W  = 4;
`ifdef PED_REQUEST_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       ped_req;
  logic       walk;
  logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [2:0] phase;

  always #5 clk = ~clk;

  traffic_light_phase_controller #(
    .GREEN_CYCLES (G),
    .YELLOW_CYCLES(Y),
    .ALLRED_CYCLES(AR),
    .WALK_CYCLES  (W),
    .CNT_W        (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .ns_red   (ns_red),
    .ns_yellow(ns_yellow),
    .ns_green (ns_green),
    .ew_red   (ew_red),
    .ew_yellow(ew_yellow),
    .ew_green (ew_green),
    .phase    (phase)
`ifdef PED_REQUEST_EN
    ,
    .ped_req  (ped_req),
    .walk     (walk)
`endif
  );

`ifndef PED_REQUEST_EN
  assign walk = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard and reference model ----------------
  typedef struct packed {
    logic [2:0] phase;
    logic [5:0] lamps;
    logic       walk;
  } obs_t;

  obs_t sb[$];

  // Expected lamps per phase code {nsR,nsY,nsG,ewR,ewY,ewG}.
  logic [5:0] lamp_tab [6] = '{6'b100100, 6'b001100, 6'b010100,
                               6'b100100, 6'b100001, 6'b100010};

  int m_state, m_elapsed, m_len;
  bit m_pend, m_walk;

  function automatic int base_len(input int s);
    if (s == 1 || s == 4) return G;
    if (s == 2 || s == 5) return Y;
    return AR;
  endfunction

  function automatic obs_t observed();
    return {phase, {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}, walk};
  endfunction

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_len = AR; m_pend = 0; m_walk = 0;
    sb.delete();
  endtask

  // Advance the model across one edge with inputs (e, p); push the expectation.
  task automatic model_edge(input bit e, input bit p);
    bit req;
    obs_t x;
    req = m_pend | (PED & p);
    if (e && (m_elapsed + 1 == m_len)) begin
      m_state   = (m_state + 1) % 6;
      m_elapsed = 0;
      if (PED && (m_state == 0 || m_state == 3) && req) begin
        m_len = W; m_walk = 1; m_pend = 0;
      end else begin
        m_len = base_len(m_state); m_walk = 0; m_pend = req;
      end
    end else begin
      if (e) m_elapsed++;
      m_pend = req;
    end
    x.phase = 3'(m_state);
    x.lamps = lamp_tab[m_state];
    x.walk  = m_walk;
    sb.push_back(x);
  endtask

  // Drive one cycle of stimulus, then compare against the popped expectation.
  task automatic step(input bit e, input bit p);
    obs_t x;
    en = e; ped_req = p;
    model_edge(e, p);
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      x = sb.pop_front();
      check("sb_outputs", 32'(observed()), 32'(x));
    end
  endtask

  task automatic wait_for(input int ph);
    int n = 0;
    while (phase !== 3'(ph) && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    check("reach_phase", 32'(phase), 32'(ph));
  endtask

  // Measure how long the current phase lasts; optionally pulse ped_req once.
  task automatic measure(input int ph, input bit ped_first,
                         output int len, output bit all_walk, output bit any_walk);
    bit first = ped_first;
    len = 1; all_walk = walk; any_walk = walk;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, first);
      first = 1'b0;
      if (phase !== 3'(ph)) break;
      len++;
      all_walk &= walk;
      any_walk |= walk;
    end
  endtask

  // Safety invariants, sampled away from the active edge every cycle.
  always @(negedge clk) begin
    check("ns_onehot", $countones({ns_red, ns_yellow, ns_green}), 1);
    check("ew_onehot", $countones({ew_red, ew_yellow, ew_green}), 1);
    check("not_both_go", 32'(!ns_red && !ew_red), 0);
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit en;
    bit ped;
    int exp_phase;
  } vec_t;

  vec_t vecs [25];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len;
    bit all_w, any_w;

    // Full ring from reset release (phase after each edge), then en freeze in NS_G.
    vecs = '{'{1,0,1}, '{1,0,1}, '{1,0,1}, '{1,0,1}, '{1,0,1}, '{1,0,2}, '{1,0,2},
             '{1,0,3}, '{1,0,4}, '{1,0,4}, '{1,0,4}, '{1,0,4}, '{1,0,4}, '{1,0,5},
             '{1,0,5}, '{1,0,0},
             '{1,0,1}, '{1,0,1}, '{1,0,1}, '{0,0,1}, '{0,0,1}, '{0,0,1},
             '{1,0,1}, '{1,0,1}, '{1,0,2}};

    reset = 1'b1; en = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_phase", 32'(phase), 0);
    check("reset_lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'h24);
    check("reset_walk", 32'(walk), 0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].en, vecs[i].ped);
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].exp_phase));
    end

    // Asynchronous reset in the middle of EW_G.
    wait_for(4);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid_ewg", 32'(phase), 4);
    #2;
    reset = 1'b1;
    #1;
    check("async_phase", 32'(phase), 0);
    check("async_lamps", 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green}), 32'h24);
    check("async_walk", 32'(walk), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("held_reset_phase", 32'(phase), 0);
    step(1'b1, 1'b0);
    check("ar_ns_one_cycle", 32'(phase), 1);

`ifdef PED_REQUEST_EN
    // Pulse during NS_G: next AR_EW is a 4-cycle walk; a pulse during that
    // walk stretches the following AR_NS too; afterwards normal 1-cycle all-red.
    step(1'b1, 1'b1);
    wait_for(3);
    measure(3, 1'b1, len, all_w, any_w);
    check("walk_ar_ew_len", 32'(len), 4);
    check("walk_ar_ew_lamp", 32'(all_w), 1);
    wait_for(0);
    measure(0, 1'b0, len, all_w, any_w);
    check("held_req_ar_ns_len", 32'(len), 4);
    check("held_req_ar_ns_lamp", 32'(all_w), 1);
    wait_for(3);
    measure(3, 1'b0, len, all_w, any_w);
    check("plain_ar_ew_len", 32'(len), 1);
    check("plain_ar_ew_walk", 32'(any_w), 0);
    wait_for(0);
    measure(0, 1'b0, len, all_w, any_w);
    check("plain_ar_ns_len", 32'(len), 1);
    check("plain_ar_ns_walk", 32'(any_w), 0);
`else
    // Without the feature every all-red phase stays one cycle.
    wait_for(3);
    measure(3, 1'b0, len, all_w, any_w);
    check("plain_ar_ew_len", 32'(len), AR);
    wait_for(0);
    measure(0, 1'b0, len, all_w, any_w);
    check("plain_ar_ns_len", 32'(len), AR);
`endif

    check("sb_empty", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
